mult_32: RTL and testbench
==========================

MULT_32 -- requirements
Module: mult_32

Interface
REQ-001 Parameter: WIDTH, 32, operand width. Only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a multiply.
REQ-005 is_signed  input  1  1 = MIPS mult (two's complement), 0 = multu (unsigned).
REQ-006 input1  input  32  multiplicand.
REQ-007 input2  input  32  multiplier.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking that hi/lo are valid.
REQ-010 hi  output  32  upper half of the 64-bit product.
REQ-011 lo  output  32  lower half of the 64-bit product.

Function
REQ-012 States SHALL be IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch input1, input2 and is_signed, clear the accumulator and the bit counter, and enter RUN.
REQ-014 In IDLE or DONE, start=0 SHALL go to (or stay in) IDLE.
REQ-015 In RUN, the unit SHALL process one multiplier bit per clock (shift-add) for exactly 32 clocks, counter 0..31.
REQ-016 On the edge where the counter is 31, the state SHALL move to DONE and the final product SHALL be loaded into hi/lo.
REQ-017 Latency: done SHALL be high in the cycle after the 33rd rising edge counted from the edge that sampled start.
REQ-018 busy SHALL equal (state == RUN).
REQ-019 done SHALL equal (state == DONE) and therefore lasts exactly one cycle.
REQ-020 start while in RUN SHALL be ignored, with no restart and no queuing.
REQ-021 Input changes during RUN SHALL NOT affect the result.
REQ-022 Signed mode: the unit SHALL multiply the magnitudes of both operands.
REQ-023 Signed mode: the 64-bit product SHALL be two's-complement negated iff exactly one operand is negative.
REQ-024 Signed mode: an operand of 0x80000000 SHALL be handled as magnitude 2^31.
REQ-025 Unsigned mode: operands SHALL be used as-is, with no negation.
REQ-026 hi/lo SHALL hold the last result until the next DONE load or reset; they SHALL NOT change during RUN.
REQ-027 start asserted in the DONE cycle SHALL be accepted (back-to-back), giving a new done 33 edges later.
REQ-028 Overflow cannot occur; the full 64-bit product SHALL always be delivered.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and accumulator.
REQ-030 Reset in RUN SHALL abort the operation with no done pulse; the next start after reset release SHALL behave normally.
REQ-031 start sampled while reset is high SHALL be ignored.

Structure
REQ-032 The state encoding (IDLE/RUN/DONE) and the iteration count constant (32) SHALL live in a shared processor package.
REQ-033 The accumulator add SHALL reuse the codebase's 32-bit adder as a single sub-module instance, adder_32.
REQ-034 Sign handling and the control FSM SHALL stay in mult_32.

Verification
REQ-035 Unsigned max: multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after start.
REQ-036 Signed mixed sign: mult 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 Signed corner: mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-038 Ignore while busy: start 7 x 6, then pulse start with 2 x 2 at RUN cycle 5 -> single done, hi=0, lo=0x0000002A, busy high for 32 cycles.
REQ-039 Reset mid-op: assert reset at RUN cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse.
REQ-040 Back-to-back: start in DONE cycle with 3 x 4 -> second done 33 edges later with lo=0x0000000C, and the first result stays held during RUN.

Source files
------------

// File: rtl/mult_32_pkg.sv
// mult_32_pkg -- shared control-state encoding and iteration count for the multiplier.
// Revision: 1.0
`default_nettype none

package mult_32_pkg;

  localparam int MULT_ITERS = 32;
  localparam int CNT_W      = $clog2(MULT_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

`default_nettype wire

// File: rtl/adder_32.sv
// adder_32 -- ripple-free behavioural 32-bit adder with carry in/out.
// Revision: 1.0
`default_nettype none

module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/mult_32.sv
// mult_32 -- sequential shift-add multiplier (MIPS mult/multu), one multiplier bit per clock.
// Revision: 1.0
`default_nettype none

module mult_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mult_32_pkg::*;

  mult_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   plo_q, plo_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_b, add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] prod_raw, prod_fin;

  // Two's-complement negation of 0x80000000 yields 0x80000000, i.e. 2^31 read as unsigned.
  assign a_mag = (is_signed && input1[WIDTH-1]) ? (~input1 + WIDTH'(1)) : input1;
  assign b_mag = (is_signed && input2[WIDTH-1]) ? (~input2 + WIDTH'(1)) : input2;

  assign add_b = plo_q[0] ? mcand_q : '0;

  adder_32 #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Product after this step's add and right shift; low register shifts multiplier out as product bits shift in.
  assign prod_raw = {add_cout, add_sum, plo_q[WIDTH-1:1]};
  assign prod_fin = neg_q ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    plo_d   = plo_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          mcand_d = a_mag;
          plo_d   = b_mag;
          acc_d   = '0;
          neg_d   = is_signed && (input1[WIDTH-1] ^ input2[WIDTH-1]);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = {add_cout, add_sum[WIDTH-1:1]};
        plo_d = {add_sum[0], plo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_ITERS - 1)) begin
          state_d = ST_DONE;
          hi_d    = prod_fin[2*WIDTH-1:WIDTH];
          lo_d    = prod_fin[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      plo_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      plo_q   <= plo_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_32.sv
// tb_mult_32 -- directed self-checking bench for mult_32.
// Revision: 1.0
`default_nettype none

module tb_mult_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;

  mult_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .input1    (input1),
    .input2    (input2),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start, then waits (bounded) for done; lat counts edges including the sampling edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output int busy_cnt);
    input1 = a; input2 = b; is_signed = s; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    int lat, bc, dn, held_bad;
    logic [31:0] hi_cap, lo_cap;
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b1; is_signed = 1'b0;
    input1 = 32'd3; input2 = 32'd3;

    // Reset state, with start held high during reset
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("start_in_reset_ignored", busy, 0);

    // multu max x max
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
    check("umax_latency", lat, 33);
    check("umax_busy_cycles", bc, 32);
    check("umax_hi", hi, 32'hFFFF_FFFE);
    check("umax_lo", lo, 32'h0000_0001);
    tick();
    check("done_one_cycle", done, 0);

    do_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, lat, bc);
    check("smix_latency", lat, 33);
    check("smix_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    do_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, lat, bc);
    check("umix_hilo", {hi, lo}, 64'h0000_0004_FFFF_FFF1);

    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bc);
    check("smin_sq_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat, bc);
    check("smin_x1_hilo", {hi, lo}, 64'hFFFF_FFFF_8000_0000);

    do_op(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, lat, bc);
    check("sneg_neg_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
    tick();

    // Start while busy is ignored; inputs changed mid-run must not matter
    input1 = 32'd7; input2 = 32'd6; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0; bc = busy ? 1 : 0; held_bad = 0;
    hi_cap = 32'hDEAD_BEEF; lo_cap = 32'hDEAD_BEEF;
    for (int i = 1; i < 50; i++) begin
      if (i == 5) begin input1 = 32'd2; input2 = 32'd2; start = 1'b1; end
      if (i == 6) start = 1'b0;
      tick();
      if (busy) begin
        bc++;
        if ({hi, lo} !== 64'h6) held_bad = 1;
      end
      if (done) begin dn++; hi_cap = hi; lo_cap = lo; end
    end
    check("ignore_done_count", dn, 1);
    check("ignore_busy_cycles", bc, 32);
    check("ignore_hilo", {hi_cap, lo_cap}, 64'h0000_0000_0000_002A);
    check("ignore_prev_held", held_bad, 0);

    // Back-to-back: start accepted in the DONE cycle
    do_op(32'd5, 32'd5, 1'b0, lat, bc);
    check("b2b_first_lo", lo, 32'd25);
    input1 = 32'd3; input2 = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accepted", busy, 1);
    lat = 1; held_bad = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy && {hi, lo} !== 64'd25) held_bad = 1;
    end
    check("b2b_latency", lat, 33);
    check("b2b_hilo", {hi, lo}, 64'h0000_0000_0000_000C);
    check("b2b_first_held", held_bad, 0);

    // Reset mid-operation
    input1 = 32'd9; input2 = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before_rst", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hilo", {hi, lo}, 64'h0);
    tick(); tick();
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    check("mid_rst_no_done", dn, 0);

    do_op(32'h1234_5678, 32'h0000_0010, 1'b0, lat, bc);
    check("post_rst_latency", lat, 33);
    check("post_rst_hilo", {hi, lo}, 64'h0000_0001_2345_6780);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
